// File: rtl/wvb_rdout_arb.sv
// Round-robin readout arbiter: grants a channel with a pending header, streams that
// event out of the channel's waveform RAM over valid/ready, then signals completion.
module wvb_rdout_arb #(
  parameter int P_N_CHAN     = 4,
  parameter int P_ADR_WIDTH  = 15,
  parameter int P_DATA_WIDTH = 22
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             en,
  input  logic [P_N_CHAN-1:0]              hdr_empty,
  input  logic [P_N_CHAN*P_ADR_WIDTH-1:0]  hdr_start_addr,
  input  logic [P_N_CHAN*P_ADR_WIDTH-1:0]  hdr_stop_addr,
  output logic [P_N_CHAN-1:0]              hdr_rdreq,
  output logic [P_ADR_WIDTH-1:0]           wvb_rd_addr,
  input  logic [P_N_CHAN*P_DATA_WIDTH-1:0] wvb_rd_data,
  output logic [P_N_CHAN-1:0]              wvb_rddone,
  output logic [P_DATA_WIDTH-1:0]          dout_data,
  output logic [$clog2(P_N_CHAN)-1:0]      dout_chan,
  output logic                             dout_first,
  output logic                             dout_last,
  output logic                             dout_valid,
  input  logic                             dout_ready,
  output logic                             busy
);
  localparam int CW = $clog2(P_N_CHAN);
  localparam int AW = P_ADR_WIDTH;
  localparam int DW = P_DATA_WIDTH;
  localparam logic [P_N_CHAN-1:0] ONE_HOT0 = {{(P_N_CHAN-1){1'b0}}, 1'b1};
  localparam logic [AW:0]         REM_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0]       ADR_ONE  = {{(AW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_GRANT  = 2'd1,
    S_STREAM = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       last_grant_q, last_grant_d, chan_q, chan_d;
  logic [AW-1:0]       start_q, start_d, stop_q, stop_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d, rd_addr_q, rd_addr_d;
  logic [AW:0]         rem_q, rem_d, nwords_s;
  logic                a_v_q, a_v_d, a_first_q, a_first_d, a_last_q, a_last_d;
  logic                d_v_q, d_v_d, d_first_q, d_first_d, d_last_q, d_last_d;
  logic [DW-1:0]       ent_data_q [3];
  logic [DW-1:0]       ent_data_d [3];
  logic [2:0]          ent_v_q, ent_v_d, ent_first_q, ent_first_d, ent_last_q, ent_last_d;
  logic [P_N_CHAN-1:0] hdr_rdreq_q, hdr_rdreq_d, rddone_q, rddone_d;
  logic                busy_q, busy_d;
  logic                sel_found_s;
  logic [CW-1:0]       sel_s, idx_s;
  logic                pop_s, credit_s;
  logic [2:0]          occ_s;
  logic [DW-1:0]       ret_data_s;

  // Round-robin search starting just after the last granted channel
  always_comb begin
    sel_found_s = 1'b0;
    sel_s       = '0;
    idx_s       = '0;
    for (int k = 1; k <= P_N_CHAN; k++) begin
      idx_s = CW'((int'(last_grant_q) + k) % P_N_CHAN);
      if (!sel_found_s && !hdr_empty[idx_s]) begin
        sel_found_s = 1'b1;
        sel_s       = idx_s;
      end else begin
        sel_found_s = sel_found_s;
      end
    end
  end

  // Read credit: words stored plus reads in flight never exceed the three storage slots
  always_comb begin
    pop_s    = ent_v_q[0] & dout_ready;
    occ_s    = {2'b00, ent_v_q[0]} + {2'b00, ent_v_q[1]} + {2'b00, ent_v_q[2]}
             + {2'b00, a_v_q} + {2'b00, d_v_q};
    credit_s = (occ_s <= (3'd2 + {2'b00, pop_s}));
    nwords_s = {1'b0, stop_q - start_q} + REM_ONE;
  end

  // Next-state and read-issue logic
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    chan_d       = chan_q;
    start_d      = start_q;
    stop_d       = stop_q;
    rem_d        = rem_q;
    rd_ptr_d     = rd_ptr_q;
    rd_addr_d    = rd_addr_q;
    a_v_d        = 1'b0;
    a_first_d    = 1'b0;
    a_last_d     = 1'b0;
    d_v_d        = a_v_q;
    d_first_d    = a_first_q;
    d_last_d     = a_last_q;
    hdr_rdreq_d  = '0;
    rddone_d     = '0;
    case (state_q)
      S_IDLE: begin
        if (en && sel_found_s) begin
          state_d     = S_GRANT;
          chan_d      = sel_s;
          start_d     = hdr_start_addr[int'(sel_s)*AW +: AW];
          stop_d      = hdr_stop_addr[int'(sel_s)*AW +: AW];
          hdr_rdreq_d = ONE_HOT0 << sel_s;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_GRANT: begin
        rd_addr_d = start_q;
        rd_ptr_d  = start_q + ADR_ONE;
        rem_d     = nwords_s - REM_ONE;
        a_v_d     = 1'b1;
        a_first_d = 1'b1;
        a_last_d  = (nwords_s == REM_ONE);
        state_d   = S_STREAM;
      end
      S_STREAM: begin
        if ((rem_q != '0) && credit_s) begin
          rd_addr_d = rd_ptr_q;
          rd_ptr_d  = rd_ptr_q + ADR_ONE;
          rem_d     = rem_q - REM_ONE;
          a_v_d     = 1'b1;
          a_last_d  = (rem_q == REM_ONE);
        end else begin
          a_v_d = 1'b0;
        end
        if (pop_s && ent_last_q[0]) begin
          state_d  = S_DONE;
          rddone_d = ONE_HOT0 << chan_q;
        end else begin
          state_d = S_STREAM;
        end
      end
      S_DONE: begin
        last_grant_d = chan_q;
        state_d      = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // Output storage: slot 0 drives dout, slots 1-2 absorb returning reads during stalls
  always_comb begin
    ret_data_s = wvb_rd_data[int'(chan_q)*DW +: DW];
    ent_data_d = ent_data_q;
    if (pop_s) begin
      ent_v_d       = {1'b0, ent_v_q[2:1]};
      ent_first_d   = {1'b0, ent_first_q[2:1]};
      ent_last_d    = {1'b0, ent_last_q[2:1]};
      ent_data_d[0] = ent_data_q[1];
      ent_data_d[1] = ent_data_q[2];
    end else begin
      ent_v_d     = ent_v_q;
      ent_first_d = ent_first_q;
      ent_last_d  = ent_last_q;
    end
    if (d_v_q) begin
      if (!ent_v_d[0]) begin
        ent_v_d[0] = 1'b1; ent_first_d[0] = d_first_q; ent_last_d[0] = d_last_q;
        ent_data_d[0] = ret_data_s;
      end else if (!ent_v_d[1]) begin
        ent_v_d[1] = 1'b1; ent_first_d[1] = d_first_q; ent_last_d[1] = d_last_q;
        ent_data_d[1] = ret_data_s;
      end else begin
        ent_v_d[2] = 1'b1; ent_first_d[2] = d_first_q; ent_last_d[2] = d_last_q;
        ent_data_d[2] = ret_data_s;
      end
    end else begin
      ent_v_d = ent_v_d;
    end
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      last_grant_q <= CW'(P_N_CHAN - 1);
      chan_q       <= '0;
      start_q      <= '0;
      stop_q       <= '0;
      rem_q        <= '0;
      rd_ptr_q     <= '0;
      rd_addr_q    <= '0;
      {a_v_q, a_first_q, a_last_q} <= 3'b000;
      {d_v_q, d_first_q, d_last_q} <= 3'b000;
      ent_v_q      <= 3'b000;
      ent_first_q  <= 3'b000;
      ent_last_q   <= 3'b000;
      for (int i = 0; i < 3; i++) ent_data_q[i] <= '0;
      hdr_rdreq_q  <= '0;
      rddone_q     <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      chan_q       <= chan_d;
      start_q      <= start_d;
      stop_q       <= stop_d;
      rem_q        <= rem_d;
      rd_ptr_q     <= rd_ptr_d;
      rd_addr_q    <= rd_addr_d;
      {a_v_q, a_first_q, a_last_q} <= {a_v_d, a_first_d, a_last_d};
      {d_v_q, d_first_q, d_last_q} <= {d_v_d, d_first_d, d_last_d};
      ent_v_q      <= ent_v_d;
      ent_first_q  <= ent_first_d;
      ent_last_q   <= ent_last_d;
      for (int i = 0; i < 3; i++) ent_data_q[i] <= ent_data_d[i];
      hdr_rdreq_q  <= hdr_rdreq_d;
      rddone_q     <= rddone_d;
      busy_q       <= busy_d;
    end
  end

  assign hdr_rdreq   = hdr_rdreq_q;
  assign wvb_rddone  = rddone_q;
  assign wvb_rd_addr = rd_addr_q;
  assign dout_valid  = ent_v_q[0];
  assign dout_first  = ent_first_q[0];
  assign dout_last   = ent_last_q[0];
  assign dout_data   = ent_data_q[0];
  assign dout_chan   = chan_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_wvb_rdout_arb.sv
// Scoreboard bench for wvb_rdout_arb: header FIFO and RAM models feed the DUT,
// expected words/grants/done pulses are queued at stimulus time and checked by a monitor.
module tb_wvb_rdout_arb;
  logic        clk;
  logic        rst_n;
  logic        en;
  logic [3:0]  hdr_empty;
  logic [59:0] hdr_start;
  logic [59:0] hdr_stop;
  logic [3:0]  hdr_rdreq;
  logic [14:0] wvb_rd_addr;
  logic [87:0] rd_data;
  logic [3:0]  wvb_rddone;
  logic [21:0] dout_data;
  logic [1:0]  dout_chan;
  logic        dout_first, dout_last, dout_valid, dout_ready, busy;

  typedef struct packed {
    logic [1:0]  ch;
    logic        first;
    logic        last;
    logic [21:0] data;
  } wexp_t;

  wexp_t      exp_q[$];
  logic [1:0] gr_q[$];
  logic [1:0] rd_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int acc_cnt = 0;
  logic ready_mode = 1'b0;
  logic tput_en = 1'b0;
  logic prev_hs_nl, prev_last_hs;

  logic [14:0] fs [4][8];
  logic [14:0] fe [4][8];
  logic [2:0]  wp [4] = '{3'd0, 3'd0, 3'd0, 3'd0};
  logic [2:0]  rp [4] = '{3'd0, 3'd0, 3'd0, 3'd0};

  wvb_rdout_arb #(.P_N_CHAN(4), .P_ADR_WIDTH(15), .P_DATA_WIDTH(22)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .hdr_empty(hdr_empty),
    .hdr_start_addr(hdr_start), .hdr_stop_addr(hdr_stop), .hdr_rdreq(hdr_rdreq),
    .wvb_rd_addr(wvb_rd_addr), .wvb_rd_data(rd_data), .wvb_rddone(wvb_rddone),
    .dout_data(dout_data), .dout_chan(dout_chan), .dout_first(dout_first),
    .dout_last(dout_last), .dout_valid(dout_valid), .dout_ready(dout_ready), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [21:0] ram_val(input int ch, input logic [14:0] a);
    return {3'b101, 4'(ch), a};
  endfunction

  // RAM model with one cycle registered read latency
  always @(posedge clk) begin
    for (int c = 0; c < 4; c++) rd_data[c*22 +: 22] <= ram_val(c, wvb_rd_addr);
  end

  // Show-ahead header FIFO model per channel
  always @(negedge clk) begin
    for (int c = 0; c < 4; c++) begin
      if (hdr_rdreq[c] && rp[c] != wp[c]) begin
        rp[c] <= rp[c] + 3'd1;
        hdr_empty[c] <= ((rp[c] + 3'd1) == wp[c]);
        hdr_start[c*15 +: 15] <= fs[c][rp[c] + 3'd1];
        hdr_stop[c*15 +: 15]  <= fe[c][rp[c] + 3'd1];
      end else begin
        hdr_empty[c] <= (rp[c] == wp[c]);
        hdr_start[c*15 +: 15] <= fs[c][rp[c]];
        hdr_stop[c*15 +: 15]  <= fe[c][rp[c]];
      end
    end
  end

  initial begin
    dout_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      dout_ready = ready_mode ? ($urandom_range(0, 99) < 30) : 1'b1;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_note(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: observed an event, expected none (t=%0t)", name, $time);
  endtask

  // Monitor: compares every presented word, grant pulse and done pulse against the queues
  always @(negedge clk) begin
    logic [1:0] ec;
    if (!rst_n) begin
      prev_hs_nl   <= 1'b0;
      prev_last_hs <= 1'b0;
    end else begin
      if (dout_valid) begin
        if (exp_q.size() == 0) fail_note("unexp_word");
        else begin
          check("word", {dout_chan, dout_first, dout_last, dout_data}, exp_q[0]);
          if (dout_ready) begin
            void'(exp_q.pop_front());
            acc_cnt++;
          end
        end
      end
      if (tput_en && prev_hs_nl && dout_ready) check("tput", dout_valid, 1);
      if (wvb_rddone != 4'd0) begin
        if (rd_q.size() == 0) fail_note("unexp_rddone");
        else begin
          ec = rd_q.pop_front();
          check("rddone", wvb_rddone, 4'b0001 << ec);
          check("rddone_lat", prev_last_hs, 1);
        end
      end else if (prev_last_hs) begin
        fail_note("rddone_missing");
      end
      if (hdr_rdreq != 4'd0) begin
        if (gr_q.size() == 0) fail_note("unexp_grant");
        else begin
          ec = gr_q.pop_front();
          check("grant", hdr_rdreq, 4'b0001 << ec);
        end
      end
      prev_hs_nl   <= dout_valid && dout_ready && !dout_last;
      prev_last_hs <= dout_valid && dout_ready && dout_last;
    end
  end

  task automatic add_hdr(input int ch, input logic [14:0] s, input logic [14:0] e);
    fs[ch][wp[ch]] = s;
    fe[ch][wp[ch]] = e;
    wp[ch] = wp[ch] + 3'd1;
  endtask

  task automatic expect_event(input int ch, input logic [14:0] s, input logic [14:0] e);
    logic [14:0] d;
    logic [14:0] a;
    int n;
    d = e - s;
    n = int'(d) + 1;
    for (int i = 0; i < n; i++) begin
      a = s + 15'(i);
      exp_q.push_back({2'(ch), (i == 0), (i == n - 1), ram_val(ch, a)});
    end
    gr_q.push_back(2'(ch));
    rd_q.push_back(2'(ch));
  endtask

  task automatic wait_drain(input int budget, input string tag);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || rd_q.size() != 0 || gr_q.size() != 0 || busy) && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    check(tag, 64'(exp_q.size() + rd_q.size() + gr_q.size()) | 64'(busy), 0);
  endtask

  task automatic chk_zero(input string tag);
    check({tag, "_rdreq"}, hdr_rdreq, 0);
    check({tag, "_rddone"}, wvb_rddone, 0);
    check({tag, "_valid"}, dout_valid, 0);
    check({tag, "_first"}, dout_first, 0);
    check({tag, "_last"}, dout_last, 0);
    check({tag, "_data"}, dout_data, 0);
    check({tag, "_chan"}, dout_chan, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_addr"}, wvb_rd_addr, 0);
  endtask

  initial begin
    int k;
    int base;
    rst_n = 1'b0;
    en    = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk_zero("reset");
    rst_n = 1'b1;
    en    = 1'b1;

    // round robin, two events per channel, lengths ch+2
    tput_en = 1'b1;
    for (int e = 0; e < 2; e++)
      for (int c = 0; c < 4; c++) begin
        add_hdr(c, 15'(16'h1000 * c + 16'h40 * e), 15'(16'h1000 * c + 16'h40 * e + c + 1));
        expect_event(c, 15'(16'h1000 * c + 16'h40 * e), 15'(16'h1000 * c + 16'h40 * e + c + 1));
      end
    wait_drain(2000, "rr_drain");

    // single-word event on ch2
    add_hdr(2, 15'h0100, 15'h0100);
    expect_event(2, 15'h0100, 15'h0100);
    wait_drain(200, "single_drain");

    // wrap-around and full buffer
    add_hdr(1, 15'h7FFE, 15'h0001);
    expect_event(1, 15'h7FFE, 15'h0001);
    wait_drain(200, "wrap_drain");
    add_hdr(2, 15'h0000, 15'h7FFF);
    expect_event(2, 15'h0000, 15'h7FFF);
    wait_drain(40000, "full_drain");

    // backpressure, 64 words
    tput_en    = 1'b0;
    ready_mode = 1'b1;
    add_hdr(0, 15'h2000, 15'h203F);
    expect_event(0, 15'h2000, 15'h203F);
    wait_drain(3000, "bp_drain");
    ready_mode = 1'b0;
    repeat (2) @(negedge clk);
    tput_en = 1'b1;

    // en dropped during a ch1 event with ch3 pending
    add_hdr(1, 15'h0300, 15'h0307);
    expect_event(1, 15'h0300, 15'h0307);
    k = 0;
    while (!busy && k < 50) begin
      @(negedge clk);
      #1;
      k++;
    end
    check("en_busy", busy, 1);
    en = 1'b0;
    add_hdr(3, 15'h0500, 15'h0503);
    wait_drain(200, "en_ch1_drain");
    repeat (10) @(negedge clk);
    #1;
    check("en_hold_idle", busy, 0);
    expect_event(3, 15'h0500, 15'h0503);
    @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    #1;
    check("en_resume_grant", hdr_rdreq, 4'b1000);
    wait_drain(200, "en_ch3_drain");

    // leave last grant at ch2, then abort a 40-word ch1 event after 10 words
    add_hdr(2, 15'h0600, 15'h0601);
    expect_event(2, 15'h0600, 15'h0601);
    wait_drain(200, "pre_abort_drain");
    base = acc_cnt;
    add_hdr(1, 15'h0700, 15'h0727);
    expect_event(1, 15'h0700, 15'h0727);
    k = 0;
    while (acc_cnt < base + 10 && k < 200) begin
      @(negedge clk);
      #1;
      k++;
    end
    check("abort_cnt", 64'(acc_cnt - base), 10);
    rst_n = 1'b0;
    exp_q.delete();
    rd_q.delete();
    gr_q.delete();
    @(negedge clk);
    #1;
    chk_zero("abort");
    rst_n = 1'b1;
    add_hdr(0, 15'h0800, 15'h0802);
    add_hdr(3, 15'h0900, 15'h0901);
    expect_event(0, 15'h0800, 15'h0802);
    expect_event(3, 15'h0900, 15'h0901);
    wait_drain(300, "post_abort_drain");
    repeat (5) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
